// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and line idle level.
// Latency: none (constants and types only).
// Backpressure: none (no datapath).
package uart_pkg;

    localparam int   UART_DATA_W = 8;
    localparam logic LINE_IDLE   = 1'b1;

    // TX_PARITY_BIT only exists when even parity is compiled in.
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        TX_START_BIT  = 3'd1,
        TX_DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY_BIT = 3'd3,
`endif
        TX_STOP_BIT   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with the head entry visible combinationally.
// Latency: a pushed byte is at the head one edge after the push.
// Backpressure: o_full is registered; a push while full is dropped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = UART_DATA_W
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW-1:0] w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_push  = i_push & ~r_full;
    assign w_pop   = i_pop & ~w_empty;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge i_Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter (8 data bits LSB first, 1 start, 1 stop; even parity with UART_TX_PARITY_EN).
// Latency: a byte written into an idle, empty FIFO starts its start bit one edge after the write.
// Backpressure: o_TX_Ready low while the FIFO is full; writes while not ready are dropped.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t                r_state;
    logic [CNT_W-1:0]         r_clk_cnt;
    logic [2:0]               r_bit_idx;
    logic [UART_DATA_W-1:0]   r_shift;
    logic                     r_serial;
    logic                     r_active;
    logic                     r_done;
`ifdef UART_TX_PARITY_EN
    logic                     r_parity;
`endif

    logic [UART_DATA_W-1:0]   w_head_dat;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;

    // The FSM takes the head byte whenever it is idle and something is queued.
    assign w_pop = (r_state == IDLE) && !w_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_push     (i_TX_DV),
        .i_push_dat (i_TX_Byte),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (o_FIFO_Count)
    );

    // Frame sequencer: each non-idle state lasts CLKS_PER_BIT cycles, outputs registered.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= LINE_IDLE;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_serial  <= LINE_IDLE;
                    r_active  <= 1'b0;
                    r_clk_cnt <= '0;
                    if (!w_empty) begin
                        r_shift  <= w_head_dat;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head_dat;
`endif
                        r_serial <= 1'b0;
                        r_active <= 1'b1;
                        r_state  <= TX_START_BIT;
                    end
                end
                TX_START_BIT: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_serial  <= r_shift[0];
                        r_state   <= TX_DATA_BITS;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                TX_DATA_BITS: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_serial <= r_parity;
                            r_state  <= TX_PARITY_BIT;
`else
                            r_serial <= LINE_IDLE;
                            r_state  <= TX_STOP_BIT;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY_BIT: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt <= '0;
                        r_serial  <= LINE_IDLE;
                        r_state   <= TX_STOP_BIT;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
`endif
                TX_STOP_BIT: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt <= '0;
                        r_active  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_serial  <= LINE_IDLE;
                    r_active  <= 1'b0;
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

    assign o_TX_Ready  = ~w_full;
    assign o_TX_Serial = r_serial;
    assign o_TX_Active = r_active;
    assign o_TX_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic [7:0] byt;
    logic       ready;
    logic       ser;
    logic       active;
    logic       done;
    logic [2:0] cnt;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_TX_DV      (dv),
        .i_TX_Byte    (byt),
        .o_TX_Ready   (ready),
        .o_TX_Serial  (ser),
        .o_TX_Active  (active),
        .o_TX_Done    (done),
        .o_FIFO_Count (cnt)
    );

    always #5 clk = ~clk;

    int         n_chk   = 0;
    int         n_err   = 0;
    logic [7:0] exp_q[$];
    int         rx_cnt  = 0;
    int         done_cnt = 0;
    int         cyc     = 0;
    int         starts[$];
    bit         mon_en  = 1'b0;
    logic       prev_ser = 1'b1;
    logic [7:0] mon_d;
    logic [7:0] mon_e;
`ifdef UART_TX_PARITY_EN
    logic       mon_p;
`endif

    logic [7:0] t2_b  [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    int         t2_c  [4] = '{1, 1, 2, 3};
    logic [7:0] t3_b  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
    int         t3_c  [6] = '{1, 1, 2, 3, 4, 4};
    int         t3_r  [6] = '{1, 1, 1, 1, 0, 0};
    logic [7:0] t5_b  [4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Serial receiver model: samples each bit at its centre and scores against the queue.
    always begin
        @(negedge clk);
        if (mon_en && prev_ser === 1'b1 && ser === 1'b0) begin
            starts.push_back(cyc);
            repeat (CPB / 2) @(negedge clk);
            check("start_bit", 32'(ser), 32'd0);
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) @(negedge clk);
                mon_d[j] = ser;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            mon_p = ser;
`endif
            repeat (CPB) @(negedge clk);
            check("stop_bit", 32'(ser), 32'd1);
            if (exp_q.size() == 0) begin
                check("spurious_frame", 32'(mon_d), 32'h100);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_byte", 32'(mon_d), 32'(mon_e));
`ifdef UART_TX_PARITY_EN
                check("parity_bit", 32'(mon_p), 32'(^mon_e));
`endif
            end
            rx_cnt++;
        end
        prev_ser = ser;
    end

    task automatic wait_frames(input int n, input int budget, inout int pk);
        int k;
        k = 0;
        while (rx_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
            if (int'(cnt) > pk) pk = int'(cnt);
        end
        if (rx_cnt < n) check("frame_timeout", 32'(rx_cnt), 32'(n));
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int n, pk, base, base_rx, lows, dbefore;
        rst = 1'b1;
        dv  = 1'b0;
        byt = 8'h00;
        #1;
        check("rst_serial", 32'(ser), 32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_count", 32'(cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: latency and frame length.
        @(negedge clk);
        dv = 1'b1; byt = 8'h55; exp_q.push_back(8'h55);
        @(posedge clk); #1;
        dv = 1'b0;
        check("t1_count_after_write", 32'(cnt), 32'd1);
        check("t1_line_before_pop", 32'(ser), 32'd1);
        @(posedge clk); #1;
        check("t1_start_low", 32'(ser), 32'd0);
        check("t1_active_high", 32'(active), 32'd1);
        check("t1_count_after_pop", 32'(cnt), 32'd0);
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) break;
        end
        check("t1_done_latency", 32'(n), 32'(FRAME));
        check("t1_active_at_done", 32'(active), 32'd0);
        @(posedge clk); #1;
        check("t1_done_one_cycle", 32'(done), 32'd0);
        pk = 0;
        wait_frames(1, 50, pk);

        // Four back-to-back bytes.
        base = starts.size();
        base_rx = rx_cnt;
        pk = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dv = 1'b1; byt = t2_b[i]; exp_q.push_back(t2_b[i]);
            @(posedge clk); #1;
            check("t2_count", 32'(cnt), 32'(t2_c[i]));
            if (int'(cnt) > pk) pk = int'(cnt);
        end
        @(negedge clk);
        dv = 1'b0;
        wait_frames(base_rx + 4, 4 * FRAME + 100, pk);
        check("t2_peak_count", 32'(pk), 32'd3);
        check("t2_starts", 32'(starts.size() - base), 32'd4);
        for (int j = 1; j < 4; j++) begin
            if (base + j < starts.size())
                check("t2_start_spacing", 32'(starts[base + j] - starts[base + j - 1]), 32'(FRAME + 1));
        end

        // Six writes into a depth-4 FIFO: the sixth is dropped.
        base_rx = rx_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dv = 1'b1; byt = t3_b[i];
            if (i < 5) exp_q.push_back(t3_b[i]);
            @(posedge clk); #1;
            check("t3_count", 32'(cnt), 32'(t3_c[i]));
            check("t3_ready", 32'(ready), 32'(t3_r[i]));
            if (i == 1) check("t3_pop_second_edge", 32'(ser), 32'd0);
        end
        @(negedge clk);
        dv = 1'b0;
        pk = 0;
        wait_frames(base_rx + 5, 5 * FRAME + 100, pk);
        repeat (FRAME + 20) @(negedge clk);
        check("t3_frames_sent", 32'(rx_cnt - base_rx), 32'd5);
        check("t3_count_drained", 32'(cnt), 32'd0);
        check("t3_ready_back", 32'(ready), 32'd1);

        // Reset during data bit 3 with two bytes queued.
        mon_en = 1'b0;
        @(negedge clk);
        dv = 1'b1; byt = 8'h0F;
        @(negedge clk);
        byt = 8'h11;
        @(negedge clk);
        byt = 8'h22;
        @(posedge clk); #1;
        dv = 1'b0;
        check("t4_count_queued", 32'(cnt), 32'd2);
        repeat (35) @(posedge clk);
        #1;
        check("t4_active_mid_frame", 32'(active), 32'd1);
        check("t4_bit3_value", 32'(ser), 32'd1);
        dbefore = done_cnt;
        #3;
        rst = 1'b1;
        #1;
        check("t4_rst_serial", 32'(ser), 32'd1);
        check("t4_rst_active", 32'(active), 32'd0);
        check("t4_rst_count", 32'(cnt), 32'd0);
        check("t4_rst_ready", 32'(ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ser !== 1'b1) lows++;
        end
        check("t4_line_idle_after_rst", 32'(lows), 32'd0);
        check("t4_no_done", 32'(done_cnt - dbefore), 32'd0);
        mon_en = 1'b1;
        base_rx = rx_cnt;
        @(negedge clk);
        dv = 1'b1; byt = 8'hC3; exp_q.push_back(8'hC3);
        @(negedge clk);
        dv = 1'b0;
        pk = 0;
        wait_frames(base_rx + 1, FRAME + 50, pk);

        // Loopback pattern set.
        base_rx = rx_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dv = 1'b1; byt = t5_b[i]; exp_q.push_back(t5_b[i]);
        end
        @(negedge clk);
        dv = 1'b0;
        wait_frames(base_rx + 4, 4 * FRAME + 100, pk);

        // Parity-sensitive pair (parity bits 1 and 0 when parity is built in).
        base_rx = rx_cnt;
        @(negedge clk);
        dv = 1'b1; byt = 8'h07; exp_q.push_back(8'h07);
        @(negedge clk);
        byt = 8'h03; exp_q.push_back(8'h03);
        @(negedge clk);
        dv = 1'b0;
        wait_frames(base_rx + 2, 2 * FRAME + 100, pk);

        repeat (20) @(negedge clk);
        check("done_pulses_vs_frames", 32'(done_cnt), 32'(rx_cnt));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that produces the serial stream consumed by the team's UART receiver: 8 data bits LSB-first, one start bit, one stop bit, optional even parity. Bytes are written into a small internal FIFO with a valid/ready strobe, so the host can queue several bytes. Frames go out back-to-back without software pacing. The block sits between the host/control logic and the TX pin, mirroring the receiver on the RX pin.

## Interface
Parameters:
- CLKS_PER_BIT, default 217: clock cycles per serial bit, equal to f(i_Clock)/baud. Must be ≥ 2.
- FIFO_DEPTH, default 4: byte entries in the TX FIFO. Must be a power of two and ≥ 2.

Ports:
- i_Clock  in  1: sole clock, rising edge.
- i_Reset  in  1: reset, asynchronous, active-high.
- i_TX_DV  in  1: write strobe. The byte is accepted on a rising edge when o_TX_Ready is also 1.
- i_TX_Byte  in  8: byte to queue; sampled with i_TX_DV.
- o_TX_Ready  out  1: FIFO not full, registered.
- o_TX_Serial  out  1: serial line, registered, idles high.
- o_TX_Active  out  1: high while a frame is on the line (start bit through stop bit).
- o_TX_Done  out  1: one-cycle pulse when a stop bit completes.
- o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1: number of queued bytes not yet started.

## Operation
- States:
  - IDLE: o_TX_Serial=1, o_TX_Active=0.
  - TX_START_BIT: line 0.
  - TX_DATA_BITS: bits 0..7, LSB first.
  - TX_PARITY_BIT: exists only with the macro.
  - TX_STOP_BIT: line 1.
- Transitions:
  - IDLE → TX_START_BIT when the FIFO is non-empty; that same edge pops the head into the shift register.
  - Every other state is held exactly CLKS_PER_BIT cycles.
  - TX_DATA_BITS exits after bit index 7 to TX_PARITY_BIT, or to TX_STOP_BIT when parity is disabled.
  - TX_STOP_BIT → IDLE, asserting o_TX_Done on that edge.
- Clock counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, then wraps to 0 on each bit boundary.
- Bit index: 3 bits. Reset to 0 on entering TX_DATA_BITS.
- FIFO write while full: dropped silently. Pointers, count and contents are unchanged.
- Write and pop on the same edge:
  - FIFO not full: both happen and the count is unchanged.
  - FIFO full: o_TX_Ready is still 0, so the write is dropped.
- Write to an empty FIFO while in IDLE: the byte passes through the FIFO and no bypass path exists.
- Default/illegal state: → IDLE with the line high.

## Timing
- Reset values:
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, o_FIFO_Count=0.
  - FSM in IDLE; FIFO pointers are cleared.
- Reset mid-frame aborts the frame: the line goes high asynchronously and queued bytes are discarded.
- Write accepted at edge k into an empty FIFO while IDLE:
  - o_FIFO_Count=1 after edge k.
  - Pop occurs at edge k+1; o_TX_Serial falls and o_TX_Active rises after edge k+1.
- Frame length: 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- o_TX_Done is high for the single cycle after the final stop-bit edge. o_TX_Active falls on that same edge.
- Back-to-back frames: the line stays high for CLKS_PER_BIT+1 cycles between frames (stop bit plus one IDLE cycle).
- o_TX_Ready deasserts the cycle after the write that fills the FIFO. It reasserts the cycle after the pop that frees a slot.

## Configuration
- UART_TX_PARITY_EN defined:
  - TX_PARITY_BIT is inserted after data bit 7 and lasts CLKS_PER_BIT cycles.
  - The parity value is the XOR of the 8 data bits (even parity), latched at pop time.
- Undefined: the frame is 8N1 and the TX_PARITY_BIT state and logic do not exist.

## Structure
- Shared package uart_pkg holds:
  - State encoding localparams: IDLE, TX_START_BIT, TX_DATA_BITS, TX_PARITY_BIT, TX_STOP_BIT.
  - UART_DATA_W=8.
  - The line idle level constant.
- Sub-module uart_tx_fifo:
  - Synchronous FIFO, FIFO_DEPTH×8, asynchronous active-high reset.
  - Signals: push/pop/full/empty/count, with the head data visible combinationally.
  - The FSM and baud counter stay in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=8 and FIFO_DEPTH=4.
- Write 0x55 at idle → line samples 0,1,0,1,0,1,0,1,0,1, each 8 cycles; o_TX_Done pulses 80 cycles after the start-bit edge.
- Write 0xA5,0x3C,0xFF,0x00 on consecutive cycles → all four transmitted in order; the line stays high for 9 cycles between frames; o_FIFO_Count peaks at 3.
- Six writes on consecutive cycles with the FSM initially IDLE → the head pops at the second edge; o_TX_Ready is low after the fifth write; the sixth write is dropped; exactly five frames are sent.
- Assert i_Reset during data bit 3 of 0x0F with two bytes queued → o_TX_Serial=1 immediately; o_FIFO_Count=0; no o_TX_Done pulse; the next write transmits normally.
- With UART_TX_PARITY_EN, write 0x07 → parity bit 1; write 0x03 → parity bit 0; each frame is 88 cycles.
- Loopback into the team's UART receiver (CLKS_PER_BIT=8), sending 0x00, 0xFF, 0x5A, 0x81 → the receiver reports all four bytes exactly (parity disabled).
